// File: rtl/pll_lock_sequencer_pkg.sv
// Shared definitions for the PLL lock sequencer: FSM state encodings and
// a helper used to size the shared timer.
package pll_lock_sequencer_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_PLL_RST = 3'd0;
    localparam logic [2:0] ST_WAIT1   = 3'd1;
    localparam logic [2:0] ST_WAIT2   = 3'd2;
    localparam logic [2:0] ST_STABLE  = 3'd3;
    localparam logic [2:0] ST_RUN     = 3'd4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by the
// block reset so a stale lock never survives rst_n.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Resets the cascaded PLL pair, waits for both locks to hold steadily, then
// releases the 5 MHz and 1/0.5 MHz domain resets in order; re-resets on loss.
module pll_lock_sequencer
    import pll_lock_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int RST_PULSE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES   = 500000,
    parameter int STABLE_CYCLES    = 1024,
    parameter int REL_GAP_CYCLES   = 64,
    parameter int CNT_W            = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               locked1_in,
    input  logic               locked2_in,
    output logic               pll_rst,
    output logic               rst1_n_out,
    output logic               rst2_n_out,
    output logic               all_locked,
    output logic [STATE_W-1:0] state_o,
    output logic [CNT_W-1:0]   loss_cnt,
    output logic [CNT_W-1:0]   retry_cnt
);

    localparam int MAX_P = max2(max2(RST_PULSE_CYCLES, TIMEOUT_CYCLES),
                                max2(STABLE_CYCLES, REL_GAP_CYCLES));
    localparam int TW    = $clog2(MAX_P + 1);

    localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_VAL      = TW'(REL_GAP_CYCLES);

    logic               l1;
    logic               l2;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nx;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_nx;
    logic               retry_inc;
    logic               loss_inc;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_l1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked1_in),
        .q     (l1)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_l2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked2_in),
        .q     (l2)
    );

    // Lock arrival is checked before the timeout so a coincident lock never retries.
    always_comb begin
        state_nx  = state;
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (timer == PULSE_LAST) state_nx = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (l1) begin
                    state_nx = ST_WAIT2;
                end else if (timer == TIMEOUT_LAST) begin
                    state_nx  = ST_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (!l1) begin
                    state_nx = ST_PLL_RST;
                end else if (l2) begin
                    state_nx = ST_STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    state_nx  = ST_PLL_RST;
                    retry_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!(l1 && l2)) begin
                    state_nx = ST_PLL_RST;
                end else if (timer == STABLE_LAST) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!(l1 && l2)) begin
                    state_nx = ST_PLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: state_nx = ST_PLL_RST;
        endcase
    end

    // One timer for every phase; in RUN it parks at the gap value so it cannot wrap.
    always_comb begin
        timer_nx = timer + TW'(1);
        if (state_nx != state) begin
            timer_nx = '0;
        end else if (state == ST_RUN && timer >= GAP_VAL) begin
            timer_nx = timer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_PLL_RST;
            timer      <= '0;
            pll_rst    <= 1'b1;
            rst1_n_out <= 1'b0;
            rst2_n_out <= 1'b0;
            all_locked <= 1'b0;
            loss_cnt   <= '0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            pll_rst    <= (state_nx == ST_PLL_RST);
            rst1_n_out <= (state_nx == ST_RUN);
            rst2_n_out <= (state_nx == ST_RUN) && (timer_nx >= GAP_VAL);
            all_locked <= (state_nx == ST_RUN);
            if (loss_inc && loss_cnt != '1) loss_cnt <= loss_cnt + CNT_W'(1);
            if (retry_inc && retry_cnt != '1) retry_cnt <= retry_cnt + CNT_W'(1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters;
// expected values are hand-computed cycle positions relative to rst_n release.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst_n;
    logic       locked1_in;
    logic       locked2_in;
    logic       pll_rst;
    logic       rst1_n_out;
    logic       rst2_n_out;
    logic       all_locked;
    logic [2:0] state_o;
    logic [3:0] loss_cnt;
    logic [3:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    pll_lock_sequencer #(
        .SYNC_STAGES      (2),
        .RST_PULSE_CYCLES (4),
        .TIMEOUT_CYCLES   (100),
        .STABLE_CYCLES    (8),
        .REL_GAP_CYCLES   (2),
        .CNT_W            (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked1_in (locked1_in),
        .locked2_in (locked2_in),
        .pll_rst    (pll_rst),
        .rst1_n_out (rst1_n_out),
        .rst2_n_out (rst2_n_out),
        .all_locked (all_locked),
        .state_o    (state_o),
        .loss_cnt   (loss_cnt),
        .retry_cnt  (retry_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 0);
        check({tag, "_pll_rst"}, 32'(pll_rst), 1);
        check({tag, "_rst1"}, 32'(rst1_n_out), 0);
        check({tag, "_rst2"}, 32'(rst2_n_out), 0);
        check({tag, "_all_locked"}, 32'(all_locked), 0);
    endtask

    task automatic restart();
        rst_n      = 1'b0;
        locked1_in = 1'b0;
        locked2_in = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        locked1_in = 1'b0;
        locked2_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_loss", 32'(loss_cnt), 0);
        check("reset_retry", 32'(retry_cnt), 0);

        // normal lock-up sequence
        rst_n = 1'b1;
        cyc   = 0;
        run_to(3);
        check("pulse_hold", 32'(pll_rst), 1);
        run_to(4);
        check("pulse_end", 32'(pll_rst), 0);
        check("wait1", 32'(state_o), 1);
        run_to(10);
        locked1_in = 1'b1;
        run_to(12);
        check("wait1_sync", 32'(state_o), 1);
        run_to(13);
        check("wait2", 32'(state_o), 2);
        run_to(20);
        locked2_in = 1'b1;
        run_to(23);
        check("stable", 32'(state_o), 3);
        run_to(30);
        check("stable_last", 32'(state_o), 3);
        check("stable_no_lock", 32'(all_locked), 0);
        check("stable_rst1", 32'(rst1_n_out), 0);
        run_to(31);
        check("run", 32'(state_o), 4);
        check("run_all_locked", 32'(all_locked), 1);
        check("run_rst1", 32'(rst1_n_out), 1);
        check("run_rst2_early", 32'(rst2_n_out), 0);
        check("run_pll_rst", 32'(pll_rst), 0);
        run_to(32);
        check("gap_rst2", 32'(rst2_n_out), 0);
        run_to(33);
        check("gap_done_rst2", 32'(rst2_n_out), 1);

        // one-cycle lock2 drop while running
        run_to(40);
        locked2_in = 1'b0;
        run_to(41);
        locked2_in = 1'b1;
        run_to(42);
        check("loss_pending", 32'(state_o), 4);
        run_to(43);
        check_idle_outputs("loss");
        check("loss_cnt", 32'(loss_cnt), 1);
        run_to(49);
        check("relock_stable", 32'(state_o), 3);

        // lock1 glitch during stable window
        run_to(54);
        locked1_in = 1'b0;
        run_to(55);
        locked1_in = 1'b1;
        run_to(56);
        check("glitch_pending", 32'(state_o), 3);
        run_to(57);
        check_idle_outputs("glitch");
        check("glitch_loss", 32'(loss_cnt), 1);
        run_to(70);
        check("relock2_stable", 32'(state_o), 3);
        run_to(71);
        check("relock2_run", 32'(state_o), 4);
        check("relock2_locked", 32'(all_locked), 1);

        // asynchronous reset in the middle of a cycle
        run_to(75);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check("async_loss", 32'(loss_cnt), 0);

        // no lock at all: repeated timeouts with saturation
        restart();
        run_to(103);
        check("to_before", 32'(state_o), 1);
        check("to_before_retry", 32'(retry_cnt), 0);
        run_to(104);
        check("to_state", 32'(state_o), 0);
        check("to_pll_rst", 32'(pll_rst), 1);
        check("to_retry", 32'(retry_cnt), 1);
        run_to(107);
        check("to_pulse_hold", 32'(pll_rst), 1);
        run_to(108);
        check("to_pulse_end", 32'(pll_rst), 0);
        check("to_wait1", 32'(state_o), 1);
        run_to(208);
        check("to_retry2", 32'(retry_cnt), 2);
        run_to(1559);
        check("sat_pre", 32'(retry_cnt), 14);
        run_to(1560);
        check("sat_hit", 32'(retry_cnt), 15);
        run_to(1664);
        check("sat_hold", 32'(retry_cnt), 15);
        check("sat_state", 32'(state_o), 0);

        // lock seen on the same cycle the timeout expires
        restart();
        run_to(101);
        locked1_in = 1'b1;
        run_to(103);
        check("race_wait1", 32'(state_o), 1);
        run_to(104);
        check("race_wait2", 32'(state_o), 2);
        check("race_retry", 32'(retry_cnt), 0);
        check("race_pll_rst", 32'(pll_rst), 0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
